// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory stage: FSM encoding and control bundle.
package mem_stage_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_REG_W  = 5;

    // Memory-access FSM: IDLE = nothing outstanding, WAIT = request in flight.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Control bits carried from decode through EX/MEM.
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/stage_reg.sv
// Width-parameterized pipeline register with load enable and async active-low clear.
module stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Load on enable, otherwise hold; clear to zero on reset.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: clocked state always uses <= so every register samples pre-edge values.
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM register, data-memory handshake FSM with pipeline stall,
// and MEM/WB register. Both pipeline registers double as forwarding sources.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int REG_W  = DEFAULT_REG_W
) (
    input  logic              clk,
    input  logic              rst,
    // execute-stage results
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] MemWriteData,
    input  logic [REG_W-1:0]  RegDest,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              RegWrite,
    input  logic              MemToReg,
    output logic              stall,
    // data-memory handshake
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    // EX/MEM forwarding source
    output logic [DATA_W-1:0] preData,
    output logic [REG_W-1:0]  preRegDest,
    output logic              preRegWrite,
    // MEM/WB forwarding source and write-back
    output logic [DATA_W-1:0] WBData,
    output logic [REG_W-1:0]  WBRegDest,
    output logic              WBRegWrite
);

    localparam int EXM_W = 1 + CTRL_W + 2 * DATA_W + REG_W;
    localparam int MWB_W = DATA_W + REG_W + 1;

    state_t state, state_next;

    logic              advance;
    ctrl_t             ex_ctrl;
    logic              ex_mem_op;

    logic [EXM_W-1:0]  exm_d, exm_q;
    logic              exm_valid;
    ctrl_t             exm_ctrl;
    logic [DATA_W-1:0] exm_alu;
    logic [DATA_W-1:0] exm_wdata;
    logic [REG_W-1:0]  exm_dest;
    logic              exm_mem_op;

    logic [MWB_W-1:0]  mwb_d, mwb_q;
    logic [DATA_W-1:0] wb_data_d;

    // The pipeline moves whenever no access is outstanding or the access completes now.
    assign stall   = (state == WAIT) && !dmem_ack;
    assign advance = !stall;

    assign ex_ctrl = '{
        mem_read:   MemRead,
        mem_write:  MemWrite,
        reg_write:  RegWrite,
        mem_to_reg: MemToReg
    };
    assign ex_mem_op = ex_valid && (MemRead || MemWrite);

    // ---------------- EX/MEM register ----------------
    assign exm_d = {ex_valid, ex_ctrl, ALUOut, MemWriteData, RegDest};

    stage_reg #(.W(EXM_W)) u_ex_mem (
        .clk (clk),
        .rst (rst),
        .en  (advance),
        .d   (exm_d),
        .q   (exm_q)
    );

    assign {exm_valid, exm_ctrl, exm_alu, exm_wdata, exm_dest} = exm_q;
    assign exm_mem_op = exm_valid && (exm_ctrl.mem_read || exm_ctrl.mem_write);

    // ---------------- access FSM ----------------
    // State register for the memory-access FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: whenever EX/MEM loads, the new occupant decides whether a request is pending.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        if (advance) begin
            state_next = ex_mem_op ? WAIT : IDLE;
        end
    end

    // Request fields come straight from EX/MEM, so they hold steady while stalled.
    // A combined read+write is issued as a store.
    assign dmem_req   = (state == WAIT);
    assign dmem_we    = exm_mem_op && exm_ctrl.mem_write;
    assign dmem_addr  = exm_alu;
    assign dmem_wdata = exm_wdata;

    assign preData     = exm_alu;
    assign preRegDest  = exm_dest;
    assign preRegWrite = exm_valid && exm_ctrl.reg_write;

    // ---------------- MEM/WB register ----------------
    assign wb_data_d = exm_ctrl.mem_to_reg ? dmem_rdata : exm_alu;
    assign mwb_d     = {wb_data_d, exm_dest, preRegWrite};

    stage_reg #(.W(MWB_W)) u_mem_wb (
        .clk (clk),
        .rst (rst),
        .en  (advance),
        .d   (mwb_d),
        .q   (mwb_q)
    );

    assign {WBData, WBRegDest, WBRegWrite} = mwb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random traffic,
// all compared against a transaction-level model of the stage.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ALUOut;
    logic [31:0] MemWriteData;
    logic [4:0]  RegDest;
    logic        MemRead, MemWrite, RegWrite, MemToReg;
    logic        stall;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic [31:0] preData;
    logic [4:0]  preRegDest;
    logic        preRegWrite;
    logic [31:0] WBData;
    logic [4:0]  WBRegDest;
    logic        WBRegWrite;

    mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ALUOut       (ALUOut),
        .MemWriteData (MemWriteData),
        .RegDest      (RegDest),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .RegWrite     (RegWrite),
        .MemToReg     (MemToReg),
        .stall        (stall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack),
        .preData      (preData),
        .preRegDest   (preRegDest),
        .preRegWrite  (preRegWrite),
        .WBData       (WBData),
        .WBRegDest    (WBRegDest),
        .WBRegWrite   (WBRegWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // An instruction as the execute stage presents it.
    typedef struct {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  dest;
        logic        rd, wr, rw, m2r;
    } instr_t;

    // Model: the instruction sitting in the memory stage and the last write-back.
    instr_t      m_mem;
    logic [31:0] m_wb_data;
    logic [4:0]  m_wb_dest;
    logic        m_wb_we;

    int tests_run;
    int tests_failed;
    int stall_cnt;
    logic        obs_req, obs_we;
    logic [31:0] obs_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic instr_t bubble();
        instr_t i;
        i = '{valid: 1'b0, alu: 32'h0, wd: 32'h0, dest: 5'd0, rd: 1'b0, wr: 1'b0, rw: 1'b0, m2r: 1'b0};
        return i;
    endfunction

    function automatic instr_t alu_op(input logic [4:0] dest, input logic [31:0] val);
        instr_t i;
        i = '{valid: 1'b1, alu: val, wd: 32'h0, dest: dest, rd: 1'b0, wr: 1'b0, rw: 1'b1, m2r: 1'b0};
        return i;
    endfunction

    function automatic instr_t load(input logic [4:0] dest, input logic [31:0] addr);
        instr_t i;
        i = '{valid: 1'b1, alu: addr, wd: 32'h0, dest: dest, rd: 1'b1, wr: 1'b0, rw: 1'b1, m2r: 1'b1};
        return i;
    endfunction

    function automatic instr_t store(input logic [31:0] addr, input logic [31:0] data);
        instr_t i;
        i = '{valid: 1'b1, alu: addr, wd: data, dest: 5'd0, rd: 1'b0, wr: 1'b1, rw: 1'b0, m2r: 1'b0};
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        int     r;
        r = int'($urandom_range(0, 9));
        i.valid = ($urandom_range(0, 4) != 0);
        i.alu   = $urandom;
        i.wd    = $urandom;
        i.dest  = 5'($urandom);
        i.rd    = (r < 2) || (r == 4);
        i.wr    = (r >= 2 && r < 5);
        i.rw    = 1'($urandom);
        i.m2r   = 1'($urandom);
        return i;
    endfunction

    task automatic model_reset();
        m_mem     = bubble();
        m_wb_data = 32'h0;
        m_wb_dest = 5'd0;
        m_wb_we   = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_req"}, dmem_req, 0);
        check({tag, "_we"}, dmem_we, 0);
        check({tag, "_addr"}, dmem_addr, 0);
        check({tag, "_wdata"}, dmem_wdata, 0);
        check({tag, "_preData"}, preData, 0);
        check({tag, "_preRegDest"}, preRegDest, 0);
        check({tag, "_preRegWrite"}, preRegWrite, 0);
        check({tag, "_WBData"}, WBData, 0);
        check({tag, "_WBRegDest"}, WBRegDest, 0);
        check({tag, "_WBRegWrite"}, WBRegWrite, 0);
    endtask

    // One clock: present inputs after the falling edge, compare against the model,
    // let the rising edge happen, advance the model, return at the next falling edge.
    task automatic cycle(input instr_t ins, input logic ack, input logic [31:0] rdata);
        logic busy, hold;
        ex_valid     = ins.valid;
        ALUOut       = ins.alu;
        MemWriteData = ins.wd;
        RegDest      = ins.dest;
        MemRead      = ins.rd;
        MemWrite     = ins.wr;
        RegWrite     = ins.rw;
        MemToReg     = ins.m2r;
        dmem_ack     = ack;
        dmem_rdata   = rdata;
        #1;
        // A real load/store in the stage is always waiting for its acknowledge.
        busy = m_mem.valid && (m_mem.rd || m_mem.wr);
        hold = busy && !ack;
        check("stall", stall, hold);
        check("dmem_req", dmem_req, busy);
        if (busy) begin
            check("dmem_we", dmem_we, m_mem.wr);
            check("dmem_addr", dmem_addr, m_mem.alu);
            check("dmem_wdata", dmem_wdata, m_mem.wd);
        end
        check("preData", preData, m_mem.alu);
        check("preRegDest", preRegDest, m_mem.dest);
        check("preRegWrite", preRegWrite, m_mem.valid && m_mem.rw);
        check("WBData", WBData, m_wb_data);
        check("WBRegDest", WBRegDest, m_wb_dest);
        check("WBRegWrite", WBRegWrite, m_wb_we);
        obs_req  = dmem_req;
        obs_we   = dmem_we;
        obs_addr = dmem_addr;
        if (stall) stall_cnt++;
        @(posedge clk);
        if (!hold) begin
            m_wb_data = m_mem.m2r ? rdata : m_mem.alu;
            m_wb_dest = m_mem.dest;
            m_wb_we   = m_mem.valid && m_mem.rw;
            m_mem     = ins;
        end
        @(negedge clk);
    endtask

    initial begin
        instr_t ri;
        logic   rack;
        tests_run    = 0;
        tests_failed = 0;
        stall_cnt    = 0;
        rst          = 1'b0;
        ex_valid     = 1'b0;
        ALUOut       = 32'h0;
        MemWriteData = 32'h0;
        RegDest      = 5'd0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        RegWrite     = 1'b0;
        MemToReg     = 1'b0;
        dmem_ack     = 1'b0;
        dmem_rdata   = 32'h0;
        model_reset();

        // Power-on reset.
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("por");
        rst = 1'b1;
        @(negedge clk);

        // ADD r3 = 5: write-back two edges after capture.
        cycle(alu_op(5'd3, 32'h5), 1'b0, 32'h0);
        cycle(bubble(), 1'b0, 32'h0);
        check("add_WBData", WBData, 32'h5);
        check("add_WBRegDest", WBRegDest, 3);
        check("add_WBRegWrite", WBRegWrite, 1);

        // Zero-wait load from 0x40.
        stall_cnt = 0;
        cycle(load(5'd4, 32'h40), 1'b0, 32'h0);
        cycle(bubble(), 1'b1, 32'hDEADBEEF);
        check("zw_req", obs_req, 1);
        check("zw_addr", obs_addr, 32'h40);
        check("zw_WBData", WBData, 32'hDEADBEEF);
        check("zw_stalls", stall_cnt, 0);

        // Store to 0x80 with three wait cycles; EX inputs during stall must be ignored.
        cycle(store(32'h80, 32'h1234), 1'b0, 32'h0);
        stall_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            cycle(load(5'd9, 32'hBAD0 + 32'(k)), 1'b0, $urandom);
            check("st_addr_held", obs_addr, 32'h80);
        end
        cycle(bubble(), 1'b1, 32'h0);
        check("st_we", obs_we, 1);
        check("st_stalls", stall_cnt, 3);
        check("st_WBRegWrite", WBRegWrite, 0);

        // ALU result r2 = 7 stays forwardable from MEM/WB while the next load stalls.
        cycle(alu_op(5'd2, 32'h7), 1'b0, 32'h0);
        cycle(load(5'd5, 32'h20), 1'b0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            cycle(bubble(), 1'b0, 32'h0);
            check("fwd_WBData", WBData, 32'h7);
            check("fwd_WBRegWrite", WBRegWrite, 1);
        end
        cycle(bubble(), 1'b1, 32'hCAFE0001);
        check("fwd_load_WBData", WBData, 32'hCAFE0001);

        // Back-to-back loads, each acknowledged immediately.
        cycle(load(5'd6, 32'h10), 1'b0, 32'h0);
        cycle(load(5'd7, 32'h14), 1'b1, 32'hA0A0A0A0);
        check("b2b_req1", obs_req, 1);
        check("b2b_addr1", obs_addr, 32'h10);
        check("b2b_wb1", WBData, 32'hA0A0A0A0);
        cycle(bubble(), 1'b1, 32'hB1B1B1B1);
        check("b2b_req2", obs_req, 1);
        check("b2b_addr2", obs_addr, 32'h14);
        check("b2b_wb2", WBData, 32'hB1B1B1B1);
        check("b2b_dest2", WBRegDest, 7);

        // Spurious ack while idle, then a read+write instruction issued as a store.
        cycle(bubble(), 1'b1, 32'h0);
        cycle(bubble(), 1'b1, 32'h0);
        check("spur_req", obs_req, 0);
        begin
            instr_t both;
            both    = store(32'h50, 32'h55);
            both.rd = 1'b1;
            cycle(both, 1'b1, 32'h0);
        end
        cycle(bubble(), 1'b0, 32'h0);
        check("both_we", obs_we, 1);
        check("both_stalled", stall, 1);
        cycle(bubble(), 1'b1, 32'h0);

        // Reset in the middle of an outstanding load.
        cycle(load(5'd8, 32'h60), 1'b0, 32'h0);
        #1;
        check("mid_req_before", dmem_req, 1);
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cycle(alu_op(5'd3, 32'h5), 1'b0, 32'h0);
        cycle(bubble(), 1'b0, 32'h0);
        check("post_rst_WBData", WBData, 32'h5);

        // Random traffic with random wait states and spurious acks.
        for (int n = 0; n < 600; n++) begin
            ri = rand_instr();
            if (m_mem.valid && (m_mem.rd || m_mem.wr)) begin
                rack = ($urandom_range(0, 2) == 0);
            end else begin
                rack = ($urandom_range(0, 3) == 0);
            end
            cycle(ri, rack, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
